// File: rtl/ififo_skew_pkg.sv
// Shared constants and helpers for the skewed input-activation FIFO bank.
package ififo_skew_pkg;

  localparam int DEF_COL   = 8;
  localparam int DEF_BW    = 4;
  localparam int DEF_DEPTH = 64;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Low bit index of a lane inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/ififo_lane.sv
// Single-lane circular buffer: parallel write, pop strobe, occupancy and
// a registered read port that holds its value between pops.
module ififo_lane
  import ififo_skew_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic                     i_pop,
  input  logic [BW-1:0]            i_data,
  output logic [BW-1:0]            o_data,
  output logic                     o_valid,
  output logic [cnt_w(DEPTH)-1:0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [BW-1:0] r_data;
  logic          r_valid;

  // Storage write; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (reset && i_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: a write and a pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_wr && !i_pop) begin
      r_count <= r_count + 1'b1;
    end else if (!i_wr && i_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Registered read port with a one-cycle valid strobe per pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_pop;
      if (i_pop) begin
        r_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/ififo_skew.sv
// Input-activation FIFO bank for the west edge of the systolic array.
// All lanes are written together; reads launch a wavefront that pops lane i
// i cycles after lane 0 (SKEW=1) or all lanes at once (SKEW=0).
module ififo_skew
  import ififo_skew_pkg::*;
#(
  parameter int COL   = DEF_COL,
  parameter int BW    = DEF_BW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SKEW  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COL*BW-1:0]        in,
  input  logic                     wr,
  input  logic                     rd,
  output logic [COL*BW-1:0]        out,
  output logic [COL-1:0]           o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_empty,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_ovf,
  output logic                     o_unf
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]  w_cnt [COL];
  logic [COL-1:0] w_lane_full;
  logic [COL-1:0] w_pop;
  logic           w_wr_acc;
  logic           w_rd_acc;
  logic           r_ovf;
  logic           r_unf;

  // Lane 0 pops first and every lane sees every write, so lane 0 always has
  // the lowest occupancy: its emptiness alone gates read acceptance.
  assign o_full   = |w_lane_full;
  assign o_ready  = ~o_full;
  assign o_empty  = (w_cnt[0] == '0);
  assign o_count  = w_cnt[0];
  assign w_wr_acc = wr & ~o_full;
  assign w_rd_acc = rd & ~o_empty;

  for (genvar gi = 0; gi < COL; gi++) begin : g_lane
    ififo_lane #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (w_wr_acc),
      .i_pop   (w_pop[gi]),
      .i_data  (in[lane_lo(gi, BW) +: BW]),
      .o_data  (out[lane_lo(gi, BW) +: BW]),
      .o_valid (o_valid[gi]),
      .o_count (w_cnt[gi])
    );
    assign w_lane_full[gi] = (w_cnt[gi] == CW'(DEPTH));
  end

  // Launch chain: each later lane pops one cycle after its neighbour.
  assign w_pop[0] = w_rd_acc;
  for (genvar gi = 1; gi < COL; gi++) begin : g_launch
    if (SKEW != 0) begin : g_skew
      logic r_stage;
      // One launch stage per lane; reset drops any wavefront in flight.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_stage <= 1'b0;
        end else begin
          r_stage <= w_pop[gi-1];
        end
      end
      assign w_pop[gi] = r_stage;
    end else begin : g_align
      assign w_pop[gi] = w_rd_acc;
    end
  end

  // Sticky error flags, set on the edge of the rejected request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr && o_full) begin
        r_ovf <= 1'b1;
      end
      if (rd && o_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign o_ovf = r_ovf;
  assign o_unf = r_unf;

endmodule

// File: tb/tb_ififo_skew.sv
// Scoreboard bench: one aligned and one skewed instance share stimulus; each
// accepted read pushes per-lane expected pops (due cycle + data) that are
// retired and compared against the DUT outputs after every edge.
module tb_ififo_skew;

  localparam int COL   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int W     = COL * BW;
  localparam int CW    = 7;
  localparam int HIST  = 2048;

  typedef struct packed {
    int          k;
    int          lane;
    int          due;
    logic [BW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] in;
  logic wr;
  logic rd;

  logic [W-1:0]   out_a, out_s;
  logic [COL-1:0] val_a, val_s;
  logic full_a, full_s, rdy_a, rdy_s, emp_a, emp_s, ovf_a, ovf_s, unf_a, unf_s;
  logic [CW-1:0]  cnt_a, cnt_s;

  always #5 clk = ~clk;

  ififo_skew #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .SKEW(0)) u_dut_aln (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
    .out(out_a), .o_valid(val_a), .o_full(full_a), .o_ready(rdy_a),
    .o_empty(emp_a), .o_count(cnt_a), .o_ovf(ovf_a), .o_unf(unf_a)
  );

  ififo_skew #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .SKEW(1)) u_dut_skw (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
    .out(out_s), .o_valid(val_s), .o_full(full_s), .o_ready(rdy_s),
    .o_empty(emp_s), .o_count(cnt_s), .o_ovf(ovf_s), .o_unf(unf_s)
  );

  // Model state, index 0 = aligned instance, 1 = skewed instance.
  ev_t            ev_q[$];
  logic [W-1:0]   m_hist [2][HIST];
  int             m_wr [2];
  int             m_sched [2];
  int             m_pop [2][COL];
  logic [W-1:0]   m_out [2];
  logic [COL-1:0] m_val [2];
  logic           m_ovf [2];
  logic           m_unf [2];
  string          nm [2] = '{"aln", "skw"};

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lane_cnt(input int k, input int i);
    return m_wr[k] - m_pop[k][i];
  endfunction

  function automatic logic m_full(input int k);
    for (int i = 0; i < COL; i++) begin
      if (lane_cnt(k, i) == DEPTH) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0]   d_out;
      logic [COL-1:0] d_val;
      logic [CW-1:0]  d_cnt;
      logic d_full, d_rdy, d_emp, d_ovf, d_unf;
      d_out  = (k == 0) ? out_a  : out_s;
      d_val  = (k == 0) ? val_a  : val_s;
      d_cnt  = (k == 0) ? cnt_a  : cnt_s;
      d_full = (k == 0) ? full_a : full_s;
      d_rdy  = (k == 0) ? rdy_a  : rdy_s;
      d_emp  = (k == 0) ? emp_a  : emp_s;
      d_ovf  = (k == 0) ? ovf_a  : ovf_s;
      d_unf  = (k == 0) ? unf_a  : unf_s;
      chk({nm[k], ".count"}, d_cnt, lane_cnt(k, 0));
      chk({nm[k], ".full"},  d_full, m_full(k));
      chk({nm[k], ".ready"}, d_rdy, !m_full(k));
      chk({nm[k], ".empty"}, d_emp, lane_cnt(k, 0) == 0);
      chk({nm[k], ".ovf"},   d_ovf, m_ovf[k]);
      chk({nm[k], ".unf"},   d_unf, m_unf[k]);
      chk({nm[k], ".valid"}, d_val, m_val[k]);
      chk({nm[k], ".out"},   d_out, m_out[k]);
    end
  endtask

  // One clock of stimulus: drive, advance model across the edge, compare.
  task automatic step(input logic rst_v, input logic wr_v, input logic rd_v, input logic [W-1:0] din);
    logic full_p [2];
    logic empty_p [2];
    reset = rst_v;
    wr    = wr_v;
    rd    = rd_v;
    in    = din;
    for (int k = 0; k < 2; k++) begin
      full_p[k]  = m_full(k);
      empty_p[k] = (lane_cnt(k, 0) == 0);
    end
    @(posedge clk);
    cyc++;
    if (!rst_v || wr_v || rd_v)
      $display("cyc %0d rst_n=%0b wr=%0b rd=%0b in=%h", cyc, rst_v, wr_v, rd_v, din);
    for (int k = 0; k < 2; k++) begin
      m_val[k] = '0;
      if (!rst_v) begin
        m_wr[k] = 0;
        m_sched[k] = 0;
        for (int i = 0; i < COL; i++) m_pop[k][i] = 0;
        m_out[k] = '0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
        for (int j = 0; j < ev_q.size(); ) begin
          if (ev_q[j].k == k) ev_q.delete(j);
          else j++;
        end
      end else begin
        if (wr_v && full_p[k]) m_ovf[k] = 1'b1;
        if (rd_v && empty_p[k]) m_unf[k] = 1'b1;
        if (wr_v && !full_p[k] && m_wr[k] < HIST) begin
          m_hist[k][m_wr[k]] = din;
          m_wr[k]++;
        end
        if (rd_v && !empty_p[k]) begin
          for (int i = 0; i < COL; i++) begin
            ev_t e;
            e.k    = k;
            e.lane = i;
            e.due  = cyc + ((k == 1) ? i : 0);
            e.data = m_hist[k][m_sched[k]][i*BW +: BW];
            ev_q.push_back(e);
          end
          m_sched[k]++;
        end
        for (int j = 0; j < ev_q.size(); ) begin
          if (ev_q[j].k == k && ev_q[j].due == cyc) begin
            m_val[k][ev_q[j].lane] = 1'b1;
            m_out[k][ev_q[j].lane*BW +: BW] = ev_q[j].data;
            m_pop[k][ev_q[j].lane]++;
            ev_q.delete(j);
          end else begin
            j++;
          end
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [COL-1:0] one_hot;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    in    = '0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Idle values after reset
    chk("idle.empty", emp_s, 1);
    chk("idle.ready", rdy_s, 1);
    chk("idle.count", cnt_s, 0);
    chk("idle.out",   out_s, 0);
    chk("idle.valid", val_s, 0);

    // Single wavefront of lane-index data
    step(1'b1, 1'b1, 1'b0, 32'h7654_3210);
    chk("wave.count", cnt_s, 1);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("wave.aln_valid", val_a, 8'hFF);
    chk("wave.aln_out", out_a, 32'h7654_3210);
    chk("wave.walk0", val_s, 8'h01);
    chk("wave.lane0", out_s[3:0], 0);
    for (int j = 1; j < COL; j++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      one_hot = '0;
      one_hot[j] = 1'b1;
      chk("wave.walk", val_s, one_hot);
      chk("wave.lane", out_s[j*BW +: BW], j);
      chk("wave.aln_quiet", val_a, 0);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    chk("wave.done", val_s, 0);

    // Fill, overflow, drain; pointers start at 1 so this wraps, then refill
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < DEPTH; n++) step(1'b1, 1'b1, 1'b0, W'($urandom));
      chk("fill.full",  full_s, 1);
      chk("fill.ready", rdy_s, 0);
      chk("fill.count", cnt_s, DEPTH);
      step(1'b1, 1'b1, 1'b0, W'($urandom));
      chk("fill.ovf",   ovf_s, 1);
      chk("fill.count_hold", cnt_s, DEPTH);
      for (int n = 0; n < DEPTH; n++) step(1'b1, 1'b0, 1'b1, '0);
      for (int n = 0; n < COL; n++) step(1'b1, 1'b0, 1'b0, '0);
      chk("drain.empty", emp_s, 1);
    end

    // Underflow on empty FIFO
    step(1'b1, 1'b0, 1'b1, '0);
    chk("unf.flag",  unf_s, 1);
    chk("unf.valid", val_s, 0);
    chk("unf.count", cnt_s, 0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("unf.valid_after", val_s | val_a, 0);

    // Concurrent traffic at half occupancy
    step(1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < DEPTH/2; n++) step(1'b1, 1'b1, 1'b0, W'($urandom));
    for (int n = 0; n < 200; n++) begin
      step(1'b1, 1'b1, 1'b1, W'($urandom));
      chk("conc.count", cnt_s, DEPTH/2);
    end
    for (int n = 0; n < COL; n++) step(1'b1, 1'b0, 1'b0, '0);

    // Reset three cycles into a wavefront
    step(1'b1, 1'b0, 1'b1, '0);
    chk("mid.walk0", val_s, 8'h01);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("mid.valid", val_s, 0);
    chk("mid.out",   out_s, 0);
    chk("mid.count", cnt_s, 0);
    chk("mid.empty", emp_s, 1);
    chk("mid.ready", rdy_s, 1);
    chk("mid.ovf",   ovf_s, 0);
    for (int n = 0; n < COL; n++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk("mid.late_lanes", val_s[7:3], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
